// File: rtl/i2c_rtc_target.sv
// rtl/i2c_rtc_target.sv - DS1307-style I2C real-time-clock target
//
// Purpose: I2C responder at SLAVE_ADDR holding a BCD sec/min/hour
// timekeeper (regs 0x00-0x02) and five RAM bytes (0x03-0x07), reached
// through an auto-incrementing register pointer. The bus is oversampled
// with clk; SCL is never driven.
//
// Ports:
//   clk       system clock, >= 20x SCL
//   rst_n     asynchronous active-low reset
//   scl       bus clock in
//   sda_i     bus data level in
//   sda_oe    1 = pull SDA low
//   tick_1hz  one-clk pulse per second, advances the timekeeper
//   sec_bcd   live register 0x00 (bit 7 = clock halt)
//   min_bcd   live register 0x01
//   hour_bcd  live register 0x02 (24-hour BCD)
//   busy      address matched, until next START/STOP

module i2c_rtc_target #(
  parameter logic [6:0] SLAVE_ADDR  = 7'b1101000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic       tick_1hz,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  // Synchronisers reset to 1 so an idle bus produces no edge out of reset.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_s, sda_s, scl_prev_q, sda_prev_q;
  logic rise_q, fall_q, start_q, stop_q;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      // Detected edges are registered and acted on one clk later.
      rise_q     <= scl_s & ~scl_prev_q;
      fall_q     <= ~scl_s & scl_prev_q;
      start_q    <= scl_s & scl_prev_q & sda_prev_q & ~sda_s;
      stop_q     <= scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    end
  end

  state_t      state_q, state_d;
  logic [7:0]  regs_q [0:7];
  logic [7:0]  regs_d [0:7];
  logic [7:0]  shadow_q [0:2];
  logic [7:0]  shadow_d [0:2];
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;   // received bits so far
  logic [6:0]  tx_q, tx_d;         // remaining bits of the byte being read
  logic        ack_seen_q, ack_seen_d;  // 9th SCL rise of an ACK slot passed
  logic        rw_q, rw_d;
  logic        busy_q, busy_d;
  logic        sda_oe_q, sda_oe_d;
  logic        tick_pend_q, tick_pend_d;
  logic [7:0]  rx_byte, rd_src;
  logic        bus_write;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      regs_q      <= '{default: 8'h00};
      shadow_q    <= '{default: 8'h00};
      ptr_q       <= 3'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      tx_q        <= 7'd0;
      ack_seen_q  <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      tick_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      shadow_q    <= shadow_d;
      ptr_q       <= ptr_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      ack_seen_q  <= ack_seen_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      sda_oe_q    <= sda_oe_d;
      tick_pend_q <= tick_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    shadow_d    = shadow_q;
    ptr_d       = ptr_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    ack_seen_d  = ack_seen_q;
    rw_d        = rw_q;
    busy_d      = busy_q;
    sda_oe_d    = sda_oe_q;
    tick_pend_d = 1'b0;
    bus_write   = 1'b0;
    rx_byte     = {shift_q, sda_s};
    rd_src      = (ptr_q < 3'd3) ? shadow_q[ptr_q[1:0]] : regs_q[ptr_q];

    if (stop_q) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_q) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (rise_q) begin
      case (state_q)
        ADDR, PTR, WR_DATA: begin
          shift_d   = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ack_seen_d = 1'b0;
            if (state_q == ADDR) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state_d = ADDR_ACK;
                rw_d    = rx_byte[0];
                busy_d  = 1'b1;
                // Coherent snapshot of the timekeeper for the whole read.
                if (rx_byte[0]) shadow_d = regs_q[0:2];
              end else begin
                state_d = IDLE;
              end
            end else if (state_q == PTR) begin
              ptr_d   = rx_byte[2:0];
              state_d = PTR_ACK;
            end else begin
              regs_d[ptr_q] = rx_byte;
              bus_write     = 1'b1;
              ptr_d         = ptr_q + 3'd1;
              state_d       = WR_ACK;
            end
          end
        end
        RD_DATA: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d    = RD_ACK;
            ack_seen_d = 1'b0;
          end
        end
        ADDR_ACK, PTR_ACK, WR_ACK: ack_seen_d = 1'b1;
        RD_ACK: begin
          ptr_d = ptr_q + 3'd1;
          if (sda_s) state_d = IDLE;      // master NACK ends the read
          else       ack_seen_d = 1'b1;
        end
        default: ;
      endcase
    end else if (fall_q) begin
      case (state_q)
        ADDR_ACK, PTR_ACK, WR_ACK: begin
          if (!ack_seen_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            if (state_q == ADDR_ACK && rw_q) begin
              state_d  = RD_DATA;
              tx_d     = rd_src[6:0];
              sda_oe_d = ~rd_src[7];
            end else if (state_q == ADDR_ACK) begin
              state_d = PTR;
            end else begin
              state_d = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          sda_oe_d = ~tx_q[6];
          tx_d     = {tx_q[5:0], 1'b0};
        end
        RD_ACK: begin
          if (!ack_seen_q) begin
            sda_oe_d = 1'b0;
          end else begin
            state_d   = RD_DATA;
            bit_cnt_d = 3'd0;
            tx_d      = rd_src[6:0];
            sda_oe_d  = ~rd_src[7];
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end

    // A bus write takes priority; a coincident tick is deferred one clk
    // and then applied to the freshly written values.
    if (bus_write) begin
      tick_pend_d = tick_1hz | tick_pend_q;
    end else if ((tick_1hz || tick_pend_q) && !regs_q[0][7]) begin
      if (regs_q[0] == 8'h59) begin
        regs_d[0] = 8'h00;
        if (regs_q[1] == 8'h59) begin
          regs_d[1] = 8'h00;
          regs_d[2] = (regs_q[2] == 8'h23) ? 8'h00 : bcd_inc(regs_q[2]);
        end else begin
          regs_d[1] = bcd_inc(regs_q[1]);
        end
      end else begin
        regs_d[0] = bcd_inc(regs_q[0]);
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign sec_bcd  = regs_q[0];
  assign min_bcd  = regs_q[1];
  assign hour_bcd = regs_q[2];

endmodule

// File: tb/tb_i2c_rtc_target.sv
// tb/tb_i2c_rtc_target.sv - directed self-checking bench for i2c_rtc_target
`timescale 1ns/1ps

module tb_i2c_rtc_target;

  localparam int H = 6;  // quarter SCL period in clks (SCL = clk/24)

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       tick = 1'b0;
  logic       sda_oe;
  logic [7:0] sec, min, hour;
  logic       busy;
  logic       sda_line;

  logic [7:0] sec_a, sec_b;
  int checks = 0;
  int passed = 0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_rtc_target #(.SLAVE_ADDR(7'b1101000), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .tick_1hz (tick),
    .sec_bcd  (sec),
    .min_bcd  (min),
    .hour_bcd (hour),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic hw(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period; optional tick aligned with the clk the DUT acts on
  // this bit's rising edge (sync 2 + detect 1 + act 1).
  task automatic bit_xfer(input logic b, input logic do_tick, output logic r);
    hw(H);
    sda_m = b;
    hw(H);
    scl = 1'b1;
    r = 1'b1;
    for (int i = 0; i < 2 * H; i++) begin
      @(negedge clk);
      if (do_tick && i == 2) tick = 1'b1;
      if (do_tick && i == 3) begin tick = 1'b0; sec_a = sec; end
      if (do_tick && i == 4) sec_b = sec;
      if (i == H) r = sda_line;
    end
    scl = 1'b0;
  endtask

  task automatic start_c();
    hw(H);
    sda_m = 1'b1;
    hw(H);
    scl = 1'b1;
    hw(2 * H);
    sda_m = 1'b0;
    hw(2 * H);
    scl = 1'b0;
  endtask

  task automatic stop_c();
    hw(H);
    sda_m = 1'b0;
    hw(H);
    scl = 1'b1;
    hw(2 * H);
    sda_m = 1'b1;
    hw(2 * H);
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic do_tick, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], do_tick && (i == 0), r);
    bit_xfer(1'b1, 1'b0, ack);
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic nack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, 1'b0, r);
      d[i] = r;
    end
    bit_xfer(nack, 1'b0, r);
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    hw(1);
  endtask

  initial begin
    logic a0, a1, a2, a3, a4;
    logic [7:0] d0, d1, d2;

    // Reset state
    hw(3);
    chk("rst_sda_oe", {7'd0, sda_oe}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_sec", sec, 8'h00);
    chk("rst_min", min, 8'h00);
    chk("rst_hour", hour, 8'h00);
    rst_n = 1'b1;
    hw(4);

    // Address match, pointer 0, three data bytes
    start_c();
    wr_byte(8'hD0, 1'b0, a0);
    chk("match_addr_ack", {7'd0, a0}, 8'h00);
    chk("match_busy", {7'd0, busy}, 8'h01);
    wr_byte(8'h00, 1'b0, a1);
    wr_byte(8'h30, 1'b0, a2);
    wr_byte(8'h45, 1'b0, a3);
    wr_byte(8'h12, 1'b0, a4);
    stop_c();
    chk("match_ptr_ack", {7'd0, a1}, 8'h00);
    chk("match_data_acks", {5'd0, a2, a3, a4}, 8'h00);
    chk("match_sec", sec, 8'h30);
    chk("match_min", min, 8'h45);
    chk("match_hour", hour, 8'h12);
    chk("match_ptr", {5'd0, dut.ptr_q}, 8'h03);
    chk("stop_busy", {7'd0, busy}, 8'h00);

    // Address mismatch: no ACK, following bytes ignored
    start_c();
    wr_byte(8'hA0, 1'b0, a0);
    chk("miss_nack", {7'd0, a0}, 8'h01);
    chk("miss_busy", {7'd0, busy}, 8'h00);
    wr_byte(8'h00, 1'b0, a1);
    wr_byte(8'h77, 1'b0, a2);
    stop_c();
    chk("miss_data_nack", {7'd0, a2}, 8'h01);
    chk("miss_sec", sec, 8'h30);

    // Read with repeated START
    start_c();
    wr_byte(8'hD0, 1'b0, a0);
    wr_byte(8'h00, 1'b0, a1);
    start_c();
    wr_byte(8'hD1, 1'b0, a2);
    chk("rd_addr_ack", {7'd0, a2}, 8'h00);
    rd_byte(d0, 1'b0);
    rd_byte(d1, 1'b0);
    rd_byte(d2, 1'b1);
    stop_c();
    chk("rd_b0", d0, 8'h30);
    chk("rd_b1", d1, 8'h45);
    chk("rd_b2", d2, 8'h12);
    chk("rd_release", {7'd0, sda_oe}, 8'h00);
    chk("rd_ptr", {5'd0, dut.ptr_q}, 8'h03);

    // Full rollover 23:59:59 -> 00:00:00
    start_c();
    wr_byte(8'hD0, 1'b0, a0);
    wr_byte(8'h00, 1'b0, a0);
    wr_byte(8'h59, 1'b0, a0);
    wr_byte(8'h59, 1'b0, a0);
    wr_byte(8'h23, 1'b0, a0);
    stop_c();
    chk("roll_pre_hour", hour, 8'h23);
    pulse_tick();
    chk("roll_sec", sec, 8'h00);
    chk("roll_min", min, 8'h00);
    chk("roll_hour", hour, 8'h00);

    // Clock halt freezes the timekeeper
    start_c();
    wr_byte(8'hD0, 1'b0, a0);
    wr_byte(8'h00, 1'b0, a0);
    wr_byte(8'h80, 1'b0, a0);
    stop_c();
    for (int i = 0; i < 5; i++) pulse_tick();
    chk("ch_sec", sec, 8'h80);
    chk("ch_min", min, 8'h00);

    // Tick in the same clk as the write of 0x10 to sec
    start_c();
    wr_byte(8'hD0, 1'b0, a0);
    wr_byte(8'h00, 1'b0, a0);
    wr_byte(8'h10, 1'b1, a0);
    stop_c();
    chk("coin_write_wins", sec_a, 8'h10);
    chk("coin_tick_after", sec_b, 8'h11);
    chk("coin_final", sec, 8'h11);

    // RAM[7] and pointer wrap
    start_c();
    wr_byte(8'hD0, 1'b0, a0);
    wr_byte(8'h07, 1'b0, a0);
    wr_byte(8'hA5, 1'b0, a0);
    stop_c();
    chk("wrap_ptr", {5'd0, dut.ptr_q}, 8'h00);

    // Read across the wrap, tick between bytes: bus shows the shadow
    start_c();
    wr_byte(8'hD0, 1'b0, a0);
    wr_byte(8'h07, 1'b0, a0);
    start_c();
    wr_byte(8'hD1, 1'b0, a0);
    rd_byte(d0, 1'b0);
    pulse_tick();
    rd_byte(d1, 1'b1);
    stop_c();
    chk("wrap_ram7", d0, 8'hA5);
    chk("shadow_sec_bus", d1, 8'h11);
    chk("shadow_sec_live", sec, 8'h12);

    // Reset while the target drives a 0 data bit
    start_c();
    wr_byte(8'hD0, 1'b0, a0);
    wr_byte(8'h00, 1'b0, a0);
    start_c();
    wr_byte(8'hD1, 1'b0, a0);
    hw(H);
    chk("mid_drive", {7'd0, sda_oe}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_release", {7'd0, sda_oe}, 8'h00);
    chk("mid_rst_busy", {7'd0, busy}, 8'h00);
    hw(2);
    chk("mid_rst_sec", sec, 8'h00);
    scl = 1'b1;
    sda_m = 1'b1;
    hw(4);
    rst_n = 1'b1;
    hw(10);
    chk("post_rst_oe", {7'd0, sda_oe}, 8'h00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
